instr_loader: RTL and testbench



---
 rtl/instr_loader.sv | 176 +++++++++++++++++
 tb/tb_instr_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them at their fetch addresses and holds the CPU until loaded.
module instr_loader #(
    parameter int          DEPTH          = 256,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] len_words,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] checksum
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0]     DEPTH_L  = 17'(DEPTH);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t         state;
    state_t         state_nx;
    logic [15:0]    len_r;
    logic [15:0]    word_idx;
    logic [1:0]     byte_cnt;
    logic [TW-1:0]  tcnt;
    logic [23:0]    word_buf;
    logic           start_ok;
    logic           start_bad;
    logic           xfer;
    logic           tmo;
    logic           last_word;

    // Handshake/strobe outputs are pure decodes of the state register.
    assign in_ready  = (state == RECV);
    assign wr_en     = (state == WRITE);
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign last_word = (word_idx == (len_r - 16'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and per-cycle event flags.
    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        start_bad = 1'b0;
        xfer      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if ((len_words != 16'd0) && ({1'b0, len_words} <= DEPTH_L)) begin
                        start_ok = 1'b1;
                        state_nx = RECV;
                    end else begin
                        start_bad = 1'b1;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            RECV: begin
                if (in_valid) begin
                    xfer = 1'b1;
                    if (byte_cnt == 2'd3) begin
                        state_nx = WRITE;
                    end else begin
                        state_nx = RECV;
                    end
                end else if (tcnt == TMO_LAST) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = RECV;
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_nx = DONE;
                end else begin
                    state_nx = RECV;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: word assembly, write address/data, checksum, hold and error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r    <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            tcnt     <= '0;
            word_buf <= 24'd0;
            wr_addr  <= 32'd0;
            wr_data  <= 32'd0;
            cpu_hold <= 1'b1;
            err      <= 1'b0;
            checksum <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        len_r    <= len_words;
                        word_idx <= 16'd0;
                        byte_cnt <= 2'd0;
                        tcnt     <= '0;
                        checksum <= 32'd0;
                        err      <= 1'b0;
                        cpu_hold <= 1'b1;
                    end else if (start_bad) begin
                        err <= 1'b1;
                    end
                end
                RECV: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        tcnt     <= '0;
                        case (byte_cnt)
                            2'd0:    word_buf[7:0]   <= in_data;
                            2'd1:    word_buf[15:8]  <= in_data;
                            2'd2:    word_buf[23:16] <= in_data;
                            default: begin
                                wr_data <= {in_data, word_buf};
                                wr_addr <= BASE_ADDR + {14'd0, word_idx, 2'b00};
                            end
                        endcase
                    end else if (tmo) begin
                        // Partial word is dropped; CPU stays held.
                        err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                WRITE: begin
                    checksum <= checksum ^ wr_data;
                    if (!last_word) begin
                        word_idx <= word_idx + 16'd1;
                        byte_cnt <= 2'd0;
                    end
                end
                DONE: begin
                    cpu_hold <= 1'b0;
                end
                default: begin
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a cycle-level behavioural model of the
// loader's observable outputs plus literal checks on the captured write log.
module tb_instr_loader;

    localparam int          DEPTH = 256;
    localparam int          TMO   = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, wr_en, cpu_hold, busy, done, err;
    logic [15:0] len_words;
    logic [7:0]  in_data;
    logic [31:0] wr_addr, wr_data, checksum;

    int tests_run    = 0;
    int tests_failed = 0;

    instr_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .len_words(len_words),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Model: expected output values for the current cycle.
    logic        e_in_ready, e_wr_en, e_cpu_hold, e_busy, e_done, e_err;
    logic [31:0] e_wr_addr, e_wr_data, e_checksum;
    int          m_len, m_words, m_nbytes, m_idle;
    logic [31:0] m_word;
    bit          mvalid = 1'b0;

    logic [63:0] wlog[$];
    int          done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model advanced at each rising edge from the sampled inputs.
    initial forever begin
        bit was_done, was_wr, was_rx;
        @(posedge clk);
        if (reset) begin
            e_in_ready = 1'b0; e_wr_en = 1'b0; e_cpu_hold = 1'b1; e_busy = 1'b0;
            e_done = 1'b0; e_err = 1'b0; e_wr_addr = 32'd0; e_wr_data = 32'd0;
            e_checksum = 32'd0; m_len = 0; m_words = 0; m_nbytes = 0; m_idle = 0;
            m_word = 32'd0; mvalid = 1'b1;
        end else if (mvalid) begin
            was_done = e_done; was_wr = e_wr_en; was_rx = e_in_ready;
            e_done  = 1'b0;
            e_wr_en = 1'b0;
            if (was_done) begin
                e_cpu_hold = 1'b0;
                e_busy     = 1'b0;
            end else if (was_wr) begin
                e_checksum = e_checksum ^ e_wr_data;
                m_words++;
                if (m_words == m_len) e_done = 1'b1;
                else e_in_ready = 1'b1;
            end else if (was_rx) begin
                if (in_valid) begin
                    m_word[8*m_nbytes +: 8] = in_data;
                    m_nbytes++;
                    m_idle = 0;
                    if (m_nbytes == 4) begin
                        e_wr_en    = 1'b1;
                        e_wr_addr  = BASE + 32'(4 * m_words);
                        e_wr_data  = m_word;
                        e_in_ready = 1'b0;
                        m_nbytes   = 0;
                        m_word     = 32'd0;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TMO) begin
                        e_err = 1'b1; e_in_ready = 1'b0; e_busy = 1'b0;
                    end
                end
            end else if (start) begin
                if (len_words >= 16'd1 && int'(len_words) <= DEPTH) begin
                    m_len = int'(len_words); m_words = 0; m_nbytes = 0; m_idle = 0;
                    m_word = 32'd0; e_checksum = 32'd0; e_err = 1'b0;
                    e_cpu_hold = 1'b1; e_in_ready = 1'b1; e_busy = 1'b1;
                end else begin
                    e_err = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            chk("in_ready", 32'(in_ready), 32'(e_in_ready));
            chk("wr_en",    32'(wr_en),    32'(e_wr_en));
            chk("wr_addr",  wr_addr,       e_wr_addr);
            chk("wr_data",  wr_data,       e_wr_data);
            chk("cpu_hold", 32'(cpu_hold), 32'(e_cpu_hold));
            chk("busy",     32'(busy),     32'(e_busy));
            chk("done",     32'(done),     32'(e_done));
            chk("err",      32'(err),      32'(e_err));
            chk("checksum", checksum,      e_checksum);
            if (wr_en) begin
                wlog.push_back({wr_addr, wr_data});
                chk("in_ready_during_write", 32'(in_ready), 32'd0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        start     = 1'b1;
        len_words = 16'(n);
        @(negedge clk);
        start     = 1'b0;
        len_words = 16'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL handshake_wait: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic stop_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_budget", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b1; start = 1'b0; len_words = 16'd0; in_valid = 1'b0; in_data = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_wr_addr",  wr_addr,       32'd0);

        // Single word.
        wlog.delete(); done_cnt = 0;
        do_start(1);
        send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
        stop_in();
        wait_idle(40);
        chk("t1_nwrites",  32'(wlog.size()), 32'd1);
        chk("t1_addr",     wlog[0][63:32],   32'h0000_0000);
        chk("t1_data",     wlog[0][31:0],    32'h0050_0093);
        chk("t1_checksum", checksum,         32'h0050_0093);
        chk("t1_done",     32'(done_cnt),    32'd1);
        chk("t1_cpu_hold", 32'(cpu_hold),    32'd0);
        chk("t1_err",      32'(err),         32'd0);

        // Three words with random gaps.
        wlog.delete(); done_cnt = 0;
        do_start(3);
        send_word(32'h0050_0093, 6); send_word(32'h0030_0113, 6); send_word(32'h0020_81B3, 6);
        stop_in();
        wait_idle(40);
        chk("t2_nwrites",  32'(wlog.size()), 32'd3);
        chk("t2_addr1",    wlog[1][63:32],   32'h0000_0004);
        chk("t2_addr2",    wlog[2][63:32],   32'h0000_0008);
        chk("t2_data2",    wlog[2][31:0],    32'h0020_81B3);
        chk("t2_checksum", checksum,         32'h0040_8033);

        // Illegal lengths from a fresh reset, then a valid start clears err.
        pulse_reset();
        wlog.delete();
        do_start(0);
        do_start(DEPTH + 1);
        repeat (3) @(negedge clk);
        chk("t3_err",      32'(err),         32'd1);
        chk("t3_busy",     32'(busy),        32'd0);
        chk("t3_cpu_hold", 32'(cpu_hold),    32'd1);
        chk("t3_nwrites",  32'(wlog.size()), 32'd0);
        do_start(1);
        chk("t3_err_clr",  32'(err),         32'd0);
        send_word(32'($urandom), 3);
        stop_in();
        wait_idle(40);

        // Timeout after 5 bytes of a 2-word load.
        wlog.delete(); done_cnt = 0;
        do_start(2);
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0);
        stop_in();
        wait_idle(TMO + 50);
        chk("t4_err",      32'(err),         32'd1);
        chk("t4_cpu_hold", 32'(cpu_hold),    32'd1);
        chk("t4_nwrites",  32'(wlog.size()), 32'd1);
        chk("t4_done",     32'(done_cnt),    32'd0);

        // Reset mid-word, then a fresh single-word load.
        do_start(1);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        pulse_reset();
        chk("t5_err",      32'(err),      32'd0);
        chk("t5_wr_data",  wr_data,       32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        wlog.delete();
        w = 32'($urandom);
        do_start(1);
        send_word(w, 2);
        stop_in();
        wait_idle(40);
        chk("t5_nwrites",  32'(wlog.size()), 32'd1);
        chk("t5_data",     wlog[0][31:0],    w);

        // start during RECV with another length is ignored.
        wlog.delete(); done_cnt = 0;
        do_start(2);
        send_word(32'($urandom), 2);
        send_byte(8'($urandom), 0); send_byte(8'($urandom), 0);
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1; len_words = 16'd5;
        @(negedge clk);
        start = 1'b0;
        send_byte(8'($urandom), 1); send_byte(8'($urandom), 1);
        stop_in();
        wait_idle(40);
        chk("t6_nwrites", 32'(wlog.size()), 32'd2);
        chk("t6_done",    32'(done_cnt),    32'd1);

        // Full-depth load.
        wlog.delete();
        do_start(DEPTH);
        for (int i = 0; i < DEPTH; i++) send_word(32'($urandom), 1);
        stop_in();
        wait_idle(40);
        chk("t7_nwrites",  32'(wlog.size()),       32'(DEPTH));
        chk("t7_last",     wlog[DEPTH-1][63:32],   32'h0000_03FC);
        chk("t7_cpu_hold", 32'(cpu_hold),          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
